// File: rtl/first_nios2_system_cpu_mulx_seq_if.sv
// Request/response bundle between the A stage and the iterative multiply sequencer.
interface first_nios2_system_cpu_mulx_seq_if;
  logic        A_mul_req;
  logic [1:0]  A_mul_op;
  logic [31:0] A_mul_src1;
  logic [31:0] A_mul_src2;
  logic        A_mul_busy;
  logic        A_mul_done;
  logic [31:0] A_mul_result;

  modport master (
    output A_mul_req, A_mul_op, A_mul_src1, A_mul_src2,
    input  A_mul_busy, A_mul_done, A_mul_result
  );

  modport slave (
    input  A_mul_req, A_mul_op, A_mul_src1, A_mul_src2,
    output A_mul_busy, A_mul_done, A_mul_result
  );
endinterface

// File: rtl/first_nios2_system_cpu_mulx_seq.sv
// Iterative 32x32 multiply for mul/mulxuu/mulxsu/mulxss using one registered 16x16
// unsigned multiplier, a 64-bit accumulator and a final signed high-word correction.
module first_nios2_system_cpu_mulx_seq #(
  parameter int MUL_W = 16
) (
  input  logic clk,
  input  logic reset_n,
  first_nios2_system_cpu_mulx_seq_if.slave mul_if
);

  localparam int WORD_W = 2 * MUL_W;
  localparam int ACC_W  = 4 * MUL_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_CORR  = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        r_k;
  logic [1:0]        r_op;
  logic [WORD_W-1:0] r_a;
  logic [WORD_W-1:0] r_b;
  logic [ACC_W-1:0]  r_acc;
  logic [WORD_W-1:0] r_prod;
  logic              r_done;
  logic [WORD_W-1:0] r_result;

  logic [MUL_W-1:0]  w_a_half [2];
  logic [MUL_W-1:0]  w_b_half [2];
  logic [MUL_W-1:0]  w_mul_a;
  logic [MUL_W-1:0]  w_mul_b;
  logic [WORD_W-1:0] w_product;
  logic [ACC_W-1:0]  w_prod_ext;
  logic [ACC_W-1:0]  w_addend;
  logic [ACC_W-1:0]  w_acc_sum;
  logic [WORD_W-1:0] w_sub_b;
  logic [WORD_W-1:0] w_sub_a;
  logic [WORD_W-1:0] w_corr_hi;
  logic              w_accept;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_halves
      assign w_a_half[gi] = r_a[gi*MUL_W +: MUL_W];
      assign w_b_half[gi] = r_b[gi*MUL_W +: MUL_W];
    end
  endgenerate

  // k[0] picks the half of a, k[1] the half of b: p0=aL*bL, p1=aH*bL, p2=aL*bH, p3=aH*bH.
  assign w_mul_a   = w_a_half[r_k[0]];
  assign w_mul_b   = w_b_half[r_k[1]];
  assign w_product = WORD_W'(w_mul_a) * WORD_W'(w_mul_b);

  assign w_prod_ext = {{(ACC_W-WORD_W){1'b0}}, r_prod};

  // r_prod holds the product issued one cycle earlier, so its shift follows k-1.
  always_comb begin
    w_addend = '0;
    if (r_state == ST_ISSUE) begin
      case (r_k)
        2'd1:    w_addend = w_prod_ext;
        2'd2:    w_addend = w_prod_ext << MUL_W;
        2'd3:    w_addend = w_prod_ext << MUL_W;
        default: w_addend = '0;
      endcase
    end else if (r_state == ST_DRAIN) begin
      w_addend = w_prod_ext << WORD_W;
    end
  end

  assign w_acc_sum = r_acc + w_addend;

  // Turn the unsigned high word into the signed one by subtracting the other operand
  // for each negative signed input.
  assign w_sub_b   = (r_op[1] && r_a[WORD_W-1]) ? r_b : '0;
  assign w_sub_a   = ((r_op == 2'b11) && r_b[WORD_W-1]) ? r_a : '0;
  assign w_corr_hi = r_acc[ACC_W-1:WORD_W] - w_sub_b - w_sub_a;

  assign w_accept = mul_if.A_mul_req && (r_state == ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prod <= '0;
    end else if (r_state == ST_ISSUE) begin
      r_prod <= w_product;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_k      <= '0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op    <= mul_if.A_mul_op;
            r_a     <= mul_if.A_mul_src1;
            r_b     <= mul_if.A_mul_src2;
            r_acc   <= '0;
            r_k     <= '0;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_acc <= w_acc_sum;
          r_k   <= r_k + 2'd1;
          if (r_k == 2'd3) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          r_acc   <= w_acc_sum;
          r_state <= ST_CORR;
        end
        ST_CORR: begin
          r_acc[ACC_W-1:WORD_W] <= w_corr_hi;
          r_result <= (r_op == 2'b00) ? r_acc[WORD_W-1:0] : w_corr_hi;
          r_done   <= 1'b1;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mul_if.A_mul_busy   = (r_state != ST_IDLE);
  assign mul_if.A_mul_done   = r_done;
  assign mul_if.A_mul_result = r_result;

endmodule

// File: tb/tb_first_nios2_system_cpu_mulx_seq.sv
// Directed bench for the iterative multiply sequencer: results, exact latency,
// back-to-back issue, ignored requests while busy and mid-operation reset.
module tb_first_nios2_system_cpu_mulx_seq;

  logic clk;
  logic reset_n;
  int   n_total = 0;
  int   n_pass  = 0;

  first_nios2_system_cpu_mulx_seq_if mul_if();

  first_nios2_system_cpu_mulx_seq #(.MUL_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .mul_if  (mul_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Called at a negedge; drives a request for the next rising edge.
  task automatic start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    check("idle_before_start", {31'b0, mul_if.A_mul_busy}, 32'd0);
    mul_if.A_mul_req  = 1'b1;
    mul_if.A_mul_op   = op;
    mul_if.A_mul_src1 = a;
    mul_if.A_mul_src2 = b;
  endtask

  // Follows one operation from its accepting edge to the done cycle, checking
  // busy/done every cycle; optionally pulses a conflicting request mid-flight.
  task automatic walk(input string tag, input logic [31:0] exp, input bit keep_req, input int pulse_c);
    @(posedge clk);
    #1;
    if (!keep_req) mul_if.A_mul_req = 1'b0;
    mul_if.A_mul_op   = 2'b10;
    mul_if.A_mul_src1 = 32'hDEAD_BEEF;
    mul_if.A_mul_src2 = 32'h8765_4321;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      if (c == pulse_c) begin
        mul_if.A_mul_req  = 1'b1;
        mul_if.A_mul_op   = 2'b11;
        mul_if.A_mul_src1 = 32'hFFFF_FFFF;
        mul_if.A_mul_src2 = 32'h8000_0000;
      end else if (c == pulse_c + 1) begin
        mul_if.A_mul_req = 1'b0;
      end
      if (c < 6) begin
        check({tag, "_busy_done"}, {30'b0, mul_if.A_mul_busy, mul_if.A_mul_done}, 32'd2);
        @(posedge clk);
      end else begin
        check({tag, "_done"}, {30'b0, mul_if.A_mul_busy, mul_if.A_mul_done}, 32'd1);
        check({tag, "_result"}, mul_if.A_mul_result, exp);
        $display("op %s result %h expected %h", tag, mul_if.A_mul_result, exp);
      end
    end
  endtask

  task automatic idle_check(input string tag, input int cycles, input logic [31:0] exp_result);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      check({tag, "_quiet"}, {30'b0, mul_if.A_mul_busy, mul_if.A_mul_done}, 32'd0);
    end
    check({tag, "_result_held"}, mul_if.A_mul_result, exp_result);
  endtask

  initial begin
    reset_n           = 1'b0;
    mul_if.A_mul_req  = 1'b0;
    mul_if.A_mul_op   = 2'b00;
    mul_if.A_mul_src1 = 32'h0;
    mul_if.A_mul_src2 = 32'h0;
    repeat (2) @(negedge clk);
    check("reset_busy_done", {30'b0, mul_if.A_mul_busy, mul_if.A_mul_done}, 32'd0);
    check("reset_result", mul_if.A_mul_result, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    start(2'b00, 32'h0001_0003, 32'h0002_0005);
    walk("mul_small", 32'h000B_000F, 1'b0, -10);
    start(2'b01, 32'h0001_0003, 32'h0002_0005);
    walk("mulxuu_small", 32'h0000_0002, 1'b0, -10);
    start(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    walk("mulxuu_ones", 32'hFFFF_FFFE, 1'b0, -10);
    start(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    walk("mulxss_ones", 32'h0000_0000, 1'b0, -10);
    start(2'b10, 32'hFFFF_FFFF, 32'h8000_0000);
    walk("mulxsu_min", 32'hFFFF_FFFF, 1'b0, -10);
    start(2'b11, 32'hFFFF_FFFF, 32'h8000_0000);
    walk("mulxss_min", 32'h0000_0000, 1'b0, -10);
    idle_check("after_singles", 3, 32'h0000_0000);

    // Request held high: each following op is accepted on the previous done cycle.
    start(2'b00, 32'd3, 32'd5);
    walk("b2b_0", 32'h0000_000F, 1'b1, -10);
    mul_if.A_mul_op   = 2'b00;
    mul_if.A_mul_src1 = 32'd7;
    mul_if.A_mul_src2 = 32'd6;
    walk("b2b_1", 32'h0000_002A, 1'b1, -10);
    mul_if.A_mul_op   = 2'b00;
    mul_if.A_mul_src1 = 32'h100;
    mul_if.A_mul_src2 = 32'h100;
    walk("b2b_2", 32'h0001_0000, 1'b0, -10);
    idle_check("after_b2b", 3, 32'h0001_0000);

    start(2'b00, 32'd7, 32'd6);
    walk("ignored_req", 32'h0000_002A, 1'b0, 2);
    idle_check("after_ignored", 8, 32'h0000_002A);

    start(2'b11, 32'h1234_5678, 32'h9ABC_DEF0);
    @(posedge clk);
    #1 mul_if.A_mul_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    check("midreset_busy_done", {30'b0, mul_if.A_mul_busy, mul_if.A_mul_done}, 32'd0);
    check("midreset_result", mul_if.A_mul_result, 32'h0);
    @(negedge clk);
    check("midreset_held", {30'b0, mul_if.A_mul_busy, mul_if.A_mul_done}, 32'd0);
    reset_n = 1'b1;
    idle_check("after_reset", 6, 32'h0000_0000);
    start(2'b00, 32'd7, 32'd6);
    walk("post_reset_mul", 32'h0000_002A, 1'b0, -10);
    idle_check("post_reset_single_done", 8, 32'h0000_002A);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
